// File: rtl/rv_mem_pkg.sv
// Shared definitions for the load/store path: RV32I load/store funct3 codes,
// the controller state encoding and the request legality check.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      READ,
      WRITE,
      RESP
   } lsu_state_t;

   // Encoding and alignment legality only; the address range is checked by the caller.
   function automatic logic access_illegal(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_B:          bad = 1'b0;
         F3_H:          bad = offset[0];
         F3_W:          bad = (offset != 2'b00);
         F3_BU:         bad = we;
         F3_HU:         bad = we | offset[0];
         default:       bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: extracts and extends load data from a memory word, and
// builds the merged word for sub-word stores.
module lsu_lane
   import rv_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign shifted  = word_i >> {offset_i, 3'b000};
   assign byte_sel = shifted[7:0];
   assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      load_data_o = word_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_o = {24'h000000, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'h0000, half_sel};
         default: load_data_o = word_i;
      endcase
   end

   // Only B and H stores reach the merge path; W stores bypass it entirely.
   always_comb begin
      store_word_o = word_i;
      if (funct3_i == F3_H) begin
         if (offset_i[1]) begin
            store_word_o[31:16] = wdata_i[15:0];
         end else begin
            store_word_o[15:0] = wdata_i[15:0];
         end
      end else begin
         store_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store controller in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; illegal requests answer with an error.
module load_store_unit
   import rv_mem_pkg::*;
#(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

   lsu_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        req_err;
   logic [31:0] lane_load;
   logic [31:0] lane_store;
   logic        mem_active;

   assign req_err = access_illegal(req_we, req_funct3, req_addr[1:0]) |
                    (req_addr >= ADDR_LIMIT);

   lsu_lane u_lane (
      .word_i       (mem_rd),
      .offset_i     (addr_q[1:0]),
      .funct3_i     (f3_q),
      .wdata_i      (wdata_q),
      .load_data_o  (lane_load),
      .store_word_o (lane_store)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      merge_d = merge_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = req_err;
               if (req_err) begin
                  state_d = RESP;
               end else if (!req_we) begin
                  state_d = LOAD;
               end else if (req_funct3 == F3_W) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         LOAD: begin
            rdata_d = lane_load;
            state_d = RESP;
         end
         READ: begin
            merge_d = lane_store;
            state_d = WRITE;
         end
         WRITE: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory port is decoded from state alone so an async reset silences it at once.
   assign mem_active = (state_q == LOAD) || (state_q == READ) || (state_q == WRITE);
   assign mem_a      = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_we     = (state_q == WRITE) & ~we_q ? 1'b0 : (state_q == WRITE);
   assign mem_wd     = (state_q != WRITE) ? 32'h0 :
                       (f3_q == F3_W)     ? wdata_q : merge_q;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
